// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, key schedule steps,
// byte-order helpers and the decrypt engine state encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_ADDKEY = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        return gf_mul(a, 8'h09);
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] a);
        return gf_mul(a, 8'h0b);
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] a);
        return gf_mul(a, 8'h0d);
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] a);
        return gf_mul(a, 8'h0e);
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i of a block, byte 0 in the most significant position.
    function automatic logic [7:0] get_byte(input logic [127:0] x, input int i);
        return x[127-8*i -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round; the last round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] next_st
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns
    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = get_byte(st, 4*((c - r + 4) % 4) + r);
            end
        end
        for (int i = 0; i < 16; i++) begin
            subbed[127-8*i -: 8] = inv_sbox(get_byte(shifted, i));
        end
        keyed = subbed ^ round_key;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_column(keyed[127-32*c -: 32]);
        end
        next_st = last_round ? keyed : mixed;
    end

endmodule

// File: rtl/aes_decrypt_engine.sv
// Iterative AES-128 decryption engine: one round per cycle, final round key
// cached after forward expansion, earlier round keys regenerated in reverse.
module aes_decrypt_engine
    import aes_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli
);

    state_t       state;
    state_t       state_next;
    logic [127:0] key_reg;
    logic [127:0] work_key;
    logic [127:0] st;
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic         cache_valid;
    logic [3:0]   cnt;
    logic [7:0]   rc;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;
    logic [127:0] round_out;
    logic         last_round;
    logic         cache_hit;

    assign rc         = rcon(cnt);
    assign key_fwd    = key_step_fwd(work_key, rc);
    assign key_inv    = key_step_inv(work_key, rc);
    assign last_round = (cnt == 4'd1);
    assign cache_hit  = KEY_CACHE && cache_valid && (anahtar == cache_key);

    aes_inv_round u_inv_round (
        .st         (st),
        .round_key  (key_inv),
        .last_round (last_round),
        .next_st    (round_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        hazir      = 1'b0;
        c_gecerli  = 1'b0;
        case (state)
            ST_IDLE: begin
                hazir = 1'b1;
                if (g_gecerli) state_next = cache_hit ? ST_ADDKEY : ST_KEYEXP;
            end
            ST_KEYEXP: if (cnt == NUM_ROUNDS) state_next = ST_ADDKEY;
            ST_ADDKEY: state_next = ST_ROUND;
            ST_ROUND:  if (last_round) state_next = ST_DONE;
            ST_DONE: begin
                c_gecerli  = 1'b1;
                state_next = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath: key expansion, cache update, round iteration and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg     <= '0;
            work_key    <= '0;
            st          <= '0;
            cache_key   <= '0;
            cache_rk10  <= '0;
            cache_valid <= 1'b0;
            cnt         <= '0;
            blok        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (g_gecerli) begin
                        key_reg  <= anahtar;
                        work_key <= anahtar;
                        st       <= sifre;
                        cnt      <= 4'd1;
                    end
                end
                ST_KEYEXP: begin
                    work_key <= key_fwd;
                    cnt      <= cnt + 4'd1;
                    if (cnt == NUM_ROUNDS) begin
                        cache_rk10  <= key_fwd;
                        cache_key   <= key_reg;
                        cache_valid <= 1'b1;
                    end
                end
                ST_ADDKEY: begin
                    st       <= st ^ cache_rk10;
                    work_key <= cache_rk10;
                    cnt      <= NUM_ROUNDS;
                end
                ST_ROUND: begin
                    st       <= round_out;
                    work_key <= key_inv;
                    cnt      <= cnt - 4'd1;
                    if (last_round) blok <= round_out;
                end
                default: ;
            endcase
        end
    end

endmodule
